// File: rtl/top.sv
// UART packet engine: 8N1 receiver, 4-byte-header packet parser (echo / add32 / xor32),
// TX byte queue and back-to-back 8N1 transmitter, all on one clock.
module top #(
  parameter int PRESCALE   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);

  localparam int BIT_CYCLES  = 8 * PRESCALE;
  localparam int HALF_CYCLES = 4 * PRESCALE;
  localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
  localparam int BIDX_W      = $clog2(DATA_WIDTH + 1);
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(HALF_CYCLES - 1);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_WIDTH - 1);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_XOR  = 8'hA2;

  // ---------------------------------------------------------------------------
  // Input synchronizer; rx_prev resets high so the first falling edge after
  // reset is seen as a start bit.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

  rx_state_t               rx_state, rx_state_n;
  logic [CNT_W-1:0]        rx_cnt, rx_cnt_n;
  logic [BIDX_W-1:0]       rx_bits, rx_bits_n;
  logic [DATA_WIDTH-1:0]   rx_shift, rx_shift_n;
  logic                    rx_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bits  <= rx_bits_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CNT_W'(1);
    rx_bits_n  = rx_bits;
    rx_shift_n = rx_shift;
    rx_valid   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        // Mid-start recheck filters glitches shorter than half a bit.
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_bits_n  = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
          if (rx_bits == LAST_BIT) rx_state_n = RX_STOP;
          else                     rx_bits_n  = rx_bits + BIDX_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_valid   = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_HOLD;
          end
        end
      end
      RX_HOLD: begin
        // Framing error: byte dropped, wait for the line to return high.
        rx_cnt_n = '0;
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet parser
  typedef enum logic [2:0] {
    P_OPCODE, P_RSVD, P_LEN_LO, P_LEN_HI, P_PAYLOAD, P_RESPOND
  } p_state_t;

  p_state_t               p_state, p_state_n;
  logic [7:0]             opcode;
  logic [7:0]             len_lo;
  logic [15:0]            remaining;
  logic [31:0]            acc;
  logic [31:0]            operand;
  logic [1:0]             op_pos;
  logic [1:0]             resp_idx;

  logic [7:0]             rx_byte;
  logic [15:0]            len_full;
  logic [31:0]            operand_merged;
  logic [31:0]            acc_combined;
  logic [31:0]            acc_shifted;
  logic                   is_arith;
  logic                   last_payload;

  // Queue handshake: push and pop are single-cycle strobes. A push while the
  // queue is full is silently ignored; pop is only raised when it is non-empty.
  logic                   push;
  logic [DATA_WIDTH-1:0]  push_data;
  logic                   pop;

  assign rx_byte        = 8'(rx_shift);
  assign len_full       = {rx_byte, len_lo};
  assign is_arith       = (opcode == OP_ADD) || (opcode == OP_XOR);
  assign last_payload   = (remaining == 16'd1);
  assign operand_merged = operand | ({24'd0, rx_byte} << {op_pos, 3'b000});
  assign acc_combined   = (opcode == OP_ADD) ? (acc + operand_merged) : (acc ^ operand_merged);
  assign acc_shifted    = acc >> {resp_idx, 3'b000};

  always_comb begin
    p_state_n = p_state;
    push      = 1'b0;
    push_data = rx_shift;
    case (p_state)
      P_OPCODE: if (rx_valid) p_state_n = P_RSVD;
      P_RSVD:   if (rx_valid) p_state_n = P_LEN_LO;
      P_LEN_LO: if (rx_valid) p_state_n = P_LEN_HI;
      P_LEN_HI: if (rx_valid) p_state_n = (len_full > 16'd4) ? P_PAYLOAD : P_OPCODE;
      P_PAYLOAD: begin
        if (rx_valid) begin
          push = (opcode == OP_ECHO);
          if (last_payload) p_state_n = is_arith ? P_RESPOND : P_OPCODE;
        end
      end
      P_RESPOND: begin
        // Four result bytes, LSB first, one per cycle; a byte arriving in this
        // short window cannot occur since a frame takes far longer.
        push      = 1'b1;
        push_data = DATA_WIDTH'(acc_shifted[7:0]);
        if (resp_idx == 2'd3) p_state_n = P_OPCODE;
      end
      default: p_state_n = P_OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_state   <= P_OPCODE;
      opcode    <= '0;
      len_lo    <= '0;
      remaining <= '0;
      acc       <= '0;
      operand   <= '0;
      op_pos    <= '0;
      resp_idx  <= '0;
    end else begin
      p_state <= p_state_n;
      case (p_state)
        P_OPCODE: begin
          if (rx_valid) begin
            opcode   <= rx_byte;
            acc      <= '0;
            operand  <= '0;
            op_pos   <= '0;
            resp_idx <= '0;
          end
        end
        P_LEN_LO: if (rx_valid) len_lo <= rx_byte;
        P_LEN_HI: if (rx_valid) remaining <= len_full - 16'd4;
        P_PAYLOAD: begin
          if (rx_valid) begin
            remaining <= remaining - 16'd1;
            // A trailing partial operand folds in zero-extended.
            if (op_pos == 2'd3 || last_payload) begin
              if (is_arith) acc <= acc_combined;
              operand <= '0;
              op_pos  <= '0;
            end else begin
              operand <= operand_merged;
              op_pos  <= op_pos + 2'd1;
            end
          end
        end
        P_RESPOND: resp_idx <= resp_idx + 2'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX byte queue
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  push_ok;
  logic                  fifo_empty;

  assign fifo_empty = (fifo_count == '0);
  assign push_ok    = push && (fifo_count != FCNT_W'(FIFO_DEPTH));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t             tx_state, tx_state_n;
  logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
  logic [BIDX_W-1:0]     tx_bits, tx_bits_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bits  <= tx_bits_n;
      tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CNT_W'(1);
    tx_bits_n  = tx_bits;
    tx_shift_n = tx_shift;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_n = mem[rd_ptr];
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_bits_n  = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          if (tx_bits == LAST_BIT) tx_state_n = TX_STOP;
          else                     tx_bits_n  = tx_bits + BIDX_W'(1);
        end
      end
      TX_STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_n = mem[rd_ptr];
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (tx_state)
      TX_START: tx_o = 1'b0;
      TX_DATA:  tx_o = tx_shift[0];
      default:  tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the UART packet engine at PRESCALE=1 (8 clocks per bit):
// serial driver on rx_i, frame monitor on tx_o, expected-byte queue scoreboard.
module tb_top;

  logic clk;
  logic rst;
  logic rx_i;
  logic tx_o;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] mon_b;
  bit         seen_low;

  top #(.PRESCALE(1), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks (all input changes on the falling edge)
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (8) @(negedge clk);
    end
    rx_i = ~bad_stop;
    repeat (8) @(negedge clk);
    if (bad_stop) begin
      rx_i = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_stim();
    while (stim_q.size() > 0) send_byte(stim_q.pop_front(), 1'b0);
  endtask

  // scoreboard: compare captured frames against the expected queue
  task automatic drain_and_compare(input string tag, input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check({tag, "_idle"}, 32'(tx_o), 32'd1);
    exp_q.delete();
    got_q.delete();
  endtask

  // tx_o frame monitor, sampling mid-bit on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_o === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          mon_b[i] = tx_o;
        end
        repeat (8) @(negedge clk);
        check("tx_stop_bit", 32'(tx_o), 32'd1);
        got_q.push_back(mon_b);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    rx_i     = 1'b1;

    // reset held 5 cycles, released, 5 quiet cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_tx_high", 32'(tx_o), 32'd1);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_tx_high", 32'(tx_o), 32'd1);
    end
    check("post_reset_no_frames", 32'(got_q.size()), 32'd0);

    // echo two bytes
    stim_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    exp_q  = '{8'h41, 8'h42};
    send_stim();
    drain_and_compare("echo", 300);

    // add32: 1 + 2
    stim_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00};
    exp_q  = '{8'h03, 8'h00, 8'h00, 8'h00};
    send_stim();
    drain_and_compare("add32", 450);

    // add32 wraps mod 2^32
    stim_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h01, 8'h00, 8'h00, 8'h00};
    exp_q  = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stim();
    drain_and_compare("add32_wrap", 450);

    // xor32: 0xFF000FF0 ^ 0x0F0F0F0F = 0xF00F00FF
    stim_q = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'hF0, 8'h0F, 8'h00, 8'hFF,
               8'h0F, 8'h0F, 8'h0F, 8'h0F};
    exp_q  = '{8'hFF, 8'h00, 8'h0F, 8'hF0};
    send_stim();
    drain_and_compare("xor32", 450);

    // add32 with a 3-byte trailing operand, zero-extended
    stim_q = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h05, 8'h01, 8'h02};
    exp_q  = '{8'h05, 8'h01, 8'h02, 8'h00};
    send_stim();
    drain_and_compare("add32_partial", 450);

    // unknown opcode swallowed, then echo
    stim_q = '{8'h55, 8'h00, 8'h05, 8'h00, 8'h77, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    exp_q  = '{8'h5A};
    send_stim();
    drain_and_compare("unknown_op", 250);

    // LEN=4 packet has no payload; next byte is a fresh opcode
    stim_q = '{8'hEC, 8'h00, 8'h04, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h66};
    exp_q  = '{8'h66};
    send_stim();
    drain_and_compare("len4", 250);

    // framing error inside an echo payload: the bad byte is dropped
    stim_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11};
    send_stim();
    send_byte(8'h22, 1'b1);
    stim_q = '{8'h33, 8'h44};
    send_stim();
    exp_q  = '{8'h11, 8'h33, 8'h44};
    drain_and_compare("frame_err", 350);

    // reset mid-packet and mid rx frame, then a fresh echo
    stim_q = '{8'hEC, 8'h00};
    send_stim();
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    check("midpkt_reset_tx_high", 32'(tx_o), 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    stim_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    exp_q  = '{8'h99};
    send_stim();
    drain_and_compare("after_reset", 250);

    // reset during a transmitted start bit abandons the frame
    stim_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    send_stim();
    seen_low = 1'b0;
    for (int i = 0; i < 200 && !seen_low; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) seen_low = 1'b1;
    end
    check("tx_frame_started", 32'(seen_low), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("tx_abandon_high", 32'(tx_o), 32'd1);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    check("tx_abandon_idle", 32'(tx_o), 32'd1);
    got_q.delete();
    exp_q.delete();

    // traffic still works after the abandoned frame
    stim_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hC3, 8'h3C};
    exp_q  = '{8'hC3, 8'h3C};
    send_stim();
    drain_and_compare("final_echo", 300);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001: Parameter PRESCALE, default 1; one UART bit period = 8*PRESCALE clk cycles.
REQ-002: Parameter DATA_WIDTH, default 8; serial data bits per frame.
REQ-003: Parameter FIFO_DEPTH, default 4; TX byte queue depth.
REQ-004: clk  input  1  single clock; all logic on its rising edge.
REQ-005: rst  input  1  reset, synchronous, active-low.
REQ-006: rx_i  input  1  UART serial in, idle high.
REQ-007: tx_o  output  1  UART serial out, idle high.

Function
REQ-008: Frame format SHALL be 8N1: start 0, DATA_WIDTH bits LSB first, one stop bit 1, each lasting 8*PRESCALE cycles.
REQ-009: rx_i SHALL pass through a 2-flop synchronizer before use.
REQ-010: Receiver SHALL detect a start on a synchronized high-to-low transition, recheck low at 4*PRESCALE cycles (otherwise return to idle), then sample each data bit and the stop bit every 8*PRESCALE cycles.
REQ-011: A stop bit sampled 0 SHALL be a frame error; the byte is discarded, and the receiver resumes idle once rx_i is high.
REQ-012: Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]; LEN = total packet bytes including the 4-byte header; payload = LEN-4 bytes.
REQ-013: Parser states: OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, RESPOND; after LEN_HI it SHALL go to PAYLOAD if LEN>4, else to OPCODE with no response.
REQ-014: Opcode 0xEC (echo): each payload byte SHALL be pushed to the TX queue in arrival order, unchanged.
REQ-015: Opcode 0xA0 (add32): payload is little-endian 32-bit operands; a trailing partial operand SHALL be zero-extended; the accumulator starts at 0 and wraps mod 2^32.
REQ-016: After the last add32 payload byte, 4 response bytes SHALL be queued, LSB first.
REQ-017: Opcode 0xA2 (xor32): same as add32, with bitwise XOR instead of addition.
REQ-018: Any other opcode SHALL consume LEN bytes and produce no response.
REQ-019: TX queue full on push SHALL drop the incoming byte; no error output.
REQ-020: Transmitter SHALL start a frame within 2 cycles of the queue being non-empty while idle, and send queued bytes back-to-back with no idle bits between frames.
REQ-021: A header byte 0 arriving after a complete packet SHALL be treated as a new opcode; there is no inter-packet timeout.

Reset
REQ-022: While rst=0 at a clk edge: all FSMs to idle/OPCODE, TX queue emptied, accumulator and counters cleared, tx_o=1.
REQ-023: Reset mid-packet or mid-frame SHALL discard partial state; a frame in progress on tx_o SHALL be abandoned with tx_o=1 the cycle after the reset edge.
REQ-024: After rst returns to 1, the first falling edge on rx_i SHALL be treated as a start bit.

Verification
REQ-025: Hold rst=0 for 5 cycles, release, wait 5 cycles -> tx_o=1 throughout, no frames.
REQ-026: Send EC 00 06 00 41 42 at PRESCALE=1 (8 cycles/bit) -> tx_o emits 0x41 then 0x42.
REQ-027: Send A0 00 0C 00 01 00 00 00 02 00 00 00 -> response 03 00 00 00.
REQ-028: Send A0 00 0C 00 FF FF FF FF 01 00 00 00 -> response 00 00 00 00 (wrap).
REQ-029: Send 55 00 05 00 77, then EC 00 05 00 5A -> only 0x5A is emitted.
REQ-030: A frame with stop bit 0 inside an echo payload -> that byte is not echoed, neighbours are; also assert rst mid-packet, then send a fresh echo packet -> correct echo.
